// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: queued results and registered write-port records.
package wb_arbiter_pkg;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                  wr_en;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] wr_data;
  } wb_ix_port_t;

  // Only results that really write a non-zero register are worth queueing.
  function automatic logic is_write_req(input logic reg_write, input logic [REG_WIDTH-1:0] rd);
    return reg_write && (rd != {REG_WIDTH{1'b0}});
  endfunction
endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result queue; ready and not_empty are flops computed from the next count,
// so a dequeue never raises ready within the same cycle.
module wb_src_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    enq,
  input  logic    deq,
  input  wb_req_t enq_req,
  output wb_req_t head,
  output logic    ready,
  output logic    not_empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  wb_req_t          mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_next_s;
  logic             ready_r;
  logic             not_empty_r;

  // Occupancy update for simultaneous enqueue/dequeue.
  always_comb begin
    count_next_s = count_r;
    case ({enq, deq})
      2'b10:   count_next_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_next_s = count_r - (PTR_W+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointer, count and status registers; pointers wrap on power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {(PTR_W+1){1'b0}};
      ready_r     <= 1'b1;
      not_empty_r <= 1'b0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r     <= count_next_s;
      ready_r     <= (count_next_s < (PTR_W+1)'(FIFO_DEPTH));
      not_empty_r <= (count_next_s != {(PTR_W+1){1'b0}});
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else if (enq) begin
      mem_r[wr_ptr_r] <= enq_req;
    end
  end

  assign head      = mem_r[rd_ptr_r];
  assign ready     = ready_r;
  assign not_empty = not_empty_r;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues execution-unit results per source and grants up to
// NUM_WR_PORTS register-file writes per cycle, round-robin, never two to the same rd.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int NUM_WR_PORTS = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC-1:0]                      src_valid,
  output logic [NUM_SRC-1:0]                      src_ready,
  input  logic [NUM_SRC-1:0]                      src_reg_write,
  input  logic [NUM_SRC-1:0][REG_WIDTH-1:0]       src_rd,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]      src_data,
  output logic [NUM_WR_PORTS-1:0]                 wb_wr_en,
  output logic [NUM_WR_PORTS-1:0][REG_WIDTH-1:0]  wb_rd,
  output logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wb_wr_data,
  output logic                                    wb_busy
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] enq_s;
  logic [NUM_SRC-1:0] deq_s;
  logic [NUM_SRC-1:0] ready_s;
  logic [NUM_SRC-1:0] not_empty_s;
  wb_req_t            enq_req_s [NUM_SRC];
  wb_req_t            head_s    [NUM_SRC];

  wb_ix_port_t        port_s [NUM_WR_PORTS];
  wb_ix_port_t        port_r [NUM_WR_PORTS];
  logic [SRC_W-1:0]   rr_ptr_r;
  logic [SRC_W-1:0]   rr_next_s;
  logic [SRC_W-1:0]   last_s;
  logic [SRC_W-1:0]   src_s;
  logic [SRC_W:0]     idx_s;
  logic [1:0]         used_s;
  logic               any_s;
  logic               conflict_s;

  // Filtered enqueue: non-writing results are accepted and dropped.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      enq_s[i]        = src_valid[i] && ready_s[i] && is_write_req(src_reg_write[i], src_rd[i]);
      enq_req_s[i].rd   = src_rd[i];
      enq_req_s[i].data = src_data[i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .enq       (enq_s[g]),
      .deq       (deq_s[g]),
      .enq_req   (enq_req_s[g]),
      .head      (head_s[g]),
      .ready     (ready_s[g]),
      .not_empty (not_empty_s[g])
    );
  end

  // Round-robin search from rr_ptr; grants fill write ports in search order.
  always_comb begin
    for (int p = 0; p < NUM_WR_PORTS; p++) port_s[p] = '0;
    deq_s      = {NUM_SRC{1'b0}};
    used_s     = 2'd0;
    any_s      = 1'b0;
    last_s     = rr_ptr_r;
    idx_s      = {(SRC_W+1){1'b0}};
    src_s      = {SRC_W{1'b0}};
    conflict_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx_s = {1'b0, rr_ptr_r} + (SRC_W+1)'(i);
      if (idx_s >= (SRC_W+1)'(NUM_SRC)) idx_s = idx_s - (SRC_W+1)'(NUM_SRC);
      else                              idx_s = idx_s;
      src_s      = idx_s[SRC_W-1:0];
      conflict_s = 1'b0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if ((2'(p) < used_s) && (port_s[p].rd == head_s[src_s].rd)) conflict_s = 1'b1;
        else                                                         conflict_s = conflict_s;
      end
      if (not_empty_s[src_s] && !conflict_s && (used_s < 2'(NUM_WR_PORTS))) begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (2'(p) == used_s) port_s[p] = '{wr_en: 1'b1, rd: head_s[src_s].rd, wr_data: head_s[src_s].data};
          else                 port_s[p] = port_s[p];
        end
        deq_s[src_s] = 1'b1;
        last_s       = src_s;
        any_s        = 1'b1;
        used_s       = used_s + 2'd1;
      end else begin
        used_s = used_s;
      end
    end
  end

  // Pointer moves just past the last granted source.
  always_comb begin
    if (!any_s)                                 rr_next_s = rr_ptr_r;
    else if (last_s == SRC_W'(NUM_SRC - 1))     rr_next_s = {SRC_W{1'b0}};
    else                                        rr_next_s = last_s + SRC_W'(1);
  end

  // Registered write ports and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= {SRC_W{1'b0}};
      for (int p = 0; p < NUM_WR_PORTS; p++) port_r[p] <= '0;
    end else begin
      rr_ptr_r <= rr_next_s;
      for (int p = 0; p < NUM_WR_PORTS; p++) port_r[p] <= port_s[p];
    end
  end

  // Unpack port records onto the flat output buses.
  always_comb begin
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      wb_wr_en[p]   = port_r[p].wr_en;
      wb_rd[p]      = port_r[p].rd;
      wb_wr_data[p] = port_r[p].wr_data;
    end
  end

  assign src_ready = ready_s;
  assign wb_busy   = |not_empty_s;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one-port instance (a) and two-port instance (b).
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  logic [3:0]                 valid_a, rw_a, ready_a;
  logic [3:0][REG_WIDTH-1:0]  rd_a;
  logic [3:0][31:0]           data_a;
  logic [0:0]                 en_a;
  logic [0:0][REG_WIDTH-1:0]  wrd_a;
  logic [0:0][31:0]           wdata_a;
  logic                       busy_a;

  logic [3:0]                 valid_b, rw_b, ready_b;
  logic [3:0][REG_WIDTH-1:0]  rd_b;
  logic [3:0][31:0]           data_b;
  logic [1:0]                 en_b;
  logic [1:0][REG_WIDTH-1:0]  wrd_b;
  logic [1:0][31:0]           wdata_b;
  logic                       busy_b;

  wb_arbiter #(.NUM_SRC(4), .FIFO_DEPTH(2), .NUM_WR_PORTS(1)) u_dut_a (
    .clk(clk), .rst(rst), .src_valid(valid_a), .src_ready(ready_a), .src_reg_write(rw_a),
    .src_rd(rd_a), .src_data(data_a), .wb_wr_en(en_a), .wb_rd(wrd_a), .wb_wr_data(wdata_a),
    .wb_busy(busy_a)
  );

  wb_arbiter #(.NUM_SRC(4), .FIFO_DEPTH(2), .NUM_WR_PORTS(2)) u_dut_b (
    .clk(clk), .rst(rst), .src_valid(valid_b), .src_ready(ready_b), .src_reg_write(rw_b),
    .src_rd(rd_b), .src_data(data_b), .wb_wr_en(en_b), .wb_rd(wrd_b), .wb_wr_data(wdata_b),
    .wb_busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_a = 4'h0; rw_a = 4'h0; rd_a = '0; data_a = '0;
    valid_b = 4'h0; rw_b = 4'h0; rd_b = '0; data_b = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (en_a !== 1'b0 || wrd_a[0] !== 5'd0 || wdata_a[0] !== 32'd0) begin
      fails++; $display("FAIL reset_wb_a: en=%b rd=%0d data=%h, required 0/0/0", en_a, wrd_a[0], wdata_a[0]);
    end
    tests_run++;
    if (busy_a !== 1'b0 || ready_a !== 4'hF) begin
      fails++; $display("FAIL reset_status_a: busy=%b ready=%b, required 0/1111", busy_a, ready_a);
    end
    tests_run++;
    if (en_b !== 2'b00 || busy_b !== 1'b0 || ready_b !== 4'hF) begin
      fails++; $display("FAIL reset_b: en=%b busy=%b ready=%b, required 00/0/1111", en_b, busy_b, ready_b);
    end
  endtask

  task automatic test_single();
    do_reset();
    valid_a[1] = 1'b1; rw_a[1] = 1'b1; rd_a[1] = 5'd5; data_a[1] = 32'hDEADBEEF;
    step();
    clear_inputs();
    tests_run++;
    if (en_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++; $display("FAIL single_queued: en=%b busy=%b, required 0/1", en_a, busy_a);
    end
    step();
    tests_run++;
    if (en_a !== 1'b1 || wrd_a[0] !== 5'd5 || wdata_a[0] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_write: en=%b rd=%0d data=%h, required 1/5/deadbeef", en_a, wrd_a[0], wdata_a[0]);
    end
    tests_run++;
    if (busy_a !== 1'b0) begin
      fails++; $display("FAIL single_busy: busy=%b, required 0", busy_a);
    end
    step();
    tests_run++;
    if (en_a !== 1'b0) begin
      fails++; $display("FAIL single_after: en=%b, required 0", en_a);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid_a[i] = 1'b1; rw_a[i] = 1'b1; rd_a[i] = 5'(i + 1); data_a[i] = 32'h100 + 32'(i);
    end
    step();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (en_a !== 1'b1 || wrd_a[0] !== 5'(k + 1) || wdata_a[0] !== 32'h100 + 32'(k)) begin
        fails++; $display("FAIL rr_order[%0d]: en=%b rd=%0d data=%h, required 1/%0d/%h",
                          k, en_a, wrd_a[0], wdata_a[0], k + 1, 32'h100 + 32'(k));
      end
    end
    step();
    tests_run++;
    if (en_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL rr_drained: en=%b busy=%b, required 0/0", en_a, busy_a);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    valid_a[0] = 1'b1; rw_a[0] = 1'b1; rd_a[0] = 5'd9; data_a[0] = 32'h99;
    step();
    clear_inputs();
    step();
    for (int i = 0; i < 4; i++) begin
      valid_a[i] = 1'b1; rw_a[i] = 1'b1; rd_a[i] = 5'd10 + 5'(i); data_a[i] = 32'hA0 + 32'(i);
    end
    step();
    clear_inputs();
    valid_a[0] = 1'b1; rw_a[0] = 1'b1; rd_a[0] = 5'd14; data_a[0] = 32'hB0;
    tests_run++;
    if (ready_a[0] !== 1'b1) begin
      fails++; $display("FAIL bp_ready_one: ready0=%b, required 1", ready_a[0]);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      clear_inputs();
      tests_run++;
      if (ready_a[0] !== 1'b0 || en_a !== 1'b1 || wrd_a[0] !== 5'd11 + 5'(k)) begin
        fails++; $display("FAIL bp_stall[%0d]: ready0=%b en=%b rd=%0d, required 0/1/%0d",
                          k, ready_a[0], en_a, wrd_a[0], 11 + k);
      end
    end
    step();
    tests_run++;
    if (en_a !== 1'b1 || wrd_a[0] !== 5'd10 || wdata_a[0] !== 32'hA0 || ready_a[0] !== 1'b1) begin
      fails++; $display("FAIL bp_drain_first: en=%b rd=%0d data=%h ready0=%b, required 1/10/a0/1",
                        en_a, wrd_a[0], wdata_a[0], ready_a[0]);
    end
    step();
    tests_run++;
    if (en_a !== 1'b1 || wrd_a[0] !== 5'd14 || wdata_a[0] !== 32'hB0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL bp_drain_second: en=%b rd=%0d data=%h busy=%b, required 1/14/b0/0",
                        en_a, wrd_a[0], wdata_a[0], busy_a);
    end
  endtask

  task automatic test_same_rd();
    do_reset();
    valid_b[0] = 1'b1; rw_b[0] = 1'b1; rd_b[0] = 5'd7; data_b[0] = 32'hA0;
    valid_b[2] = 1'b1; rw_b[2] = 1'b1; rd_b[2] = 5'd7; data_b[2] = 32'hA2;
    valid_b[3] = 1'b1; rw_b[3] = 1'b1; rd_b[3] = 5'd9; data_b[3] = 32'hA3;
    step();
    clear_inputs();
    step();
    tests_run++;
    if (en_b !== 2'b11 || wrd_b[0] !== 5'd7 || wdata_b[0] !== 32'hA0 || wrd_b[1] !== 5'd9 || wdata_b[1] !== 32'hA3) begin
      fails++; $display("FAIL samerd_first: en=%b p0=%0d/%h p1=%0d/%h, required 11 7/a0 9/a3",
                        en_b, wrd_b[0], wdata_b[0], wrd_b[1], wdata_b[1]);
    end
    step();
    tests_run++;
    if (en_b !== 2'b01 || wrd_b[0] !== 5'd7 || wdata_b[0] !== 32'hA2 || wrd_b[1] !== 5'd0 || wdata_b[1] !== 32'd0) begin
      fails++; $display("FAIL samerd_second: en=%b p0=%0d/%h p1=%0d/%h, required 01 7/a2 0/0",
                        en_b, wrd_b[0], wdata_b[0], wrd_b[1], wdata_b[1]);
    end
    step();
    tests_run++;
    if (en_b !== 2'b00 || busy_b !== 1'b0) begin
      fails++; $display("FAIL samerd_idle: en=%b busy=%b, required 00/0", en_b, busy_b);
    end
  endtask

  task automatic test_no_write();
    do_reset();
    valid_a[0] = 1'b1; rw_a[0] = 1'b0; rd_a[0] = 5'd3; data_a[0] = 32'h33;
    valid_a[1] = 1'b1; rw_a[1] = 1'b1; rd_a[1] = 5'd0; data_a[1] = 32'h44;
    tests_run++;
    if (ready_a[1:0] !== 2'b11) begin
      fails++; $display("FAIL nowrite_accept: ready=%b, required 11", ready_a[1:0]);
    end
    step();
    clear_inputs();
    tests_run++;
    if (busy_a !== 1'b0 || en_a !== 1'b0 || ready_a !== 4'hF) begin
      fails++; $display("FAIL nowrite_queue: busy=%b en=%b ready=%b, required 0/0/1111", busy_a, en_a, ready_a);
    end
    step();
    tests_run++;
    if (en_a !== 1'b0) begin
      fails++; $display("FAIL nowrite_pulse: en=%b, required 0", en_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid_a[i] = 1'b1; rw_a[i] = 1'b1; rd_a[i] = 5'd20 + 5'(i); data_a[i] = 32'hC0 + 32'(i);
    end
    step();
    clear_inputs();
    step();
    tests_run++;
    if (en_a !== 1'b1 || wrd_a[0] !== 5'd20 || busy_a !== 1'b1) begin
      fails++; $display("FAIL midrst_setup: en=%b rd=%0d busy=%b, required 1/20/1", en_a, wrd_a[0], busy_a);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (en_a !== 1'b0 || wrd_a[0] !== 5'd0 || wdata_a[0] !== 32'd0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL midrst_async: en=%b rd=%0d data=%h busy=%b, required 0/0/0/0",
                        en_a, wrd_a[0], wdata_a[0], busy_a);
    end
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (en_a !== 1'b0 || busy_a !== 1'b0) begin
        fails++; $display("FAIL midrst_after[%0d]: en=%b busy=%b, required 0/0", k, en_a, busy_a);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    rst       = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_same_rd();
    test_no_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
